alu_exec_mc: RTL and testbench
==============================

# alu_exec_mc

Multi-cycle, parametrised integer execute unit for the RV32 datapath: it decodes `ALUOp_in`/`func7`/`func3` into a 4-bit operation code, as the existing ALU control decoder does, and executes the operation on its operands. It extends the original ADD/SUB/AND/OR decode to the full RV32I integer set and the M extension (iterative multiply/divide). It sits between register read and writeback, behind a valid/ready handshake on both sides, so the pipeline stalls during long operations.

## Interface
- `XLEN`, 32, operand/result width; power of two, ≥8.
- `ENABLE_M`, 1, 1 = M-extension ops legal; 0 = `func7`=0000001 decodes as illegal.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit accepts the request this cycle.
- `ALUOp_in`  in  2  00 = load/store add, 01 = branch subtract, 10 = R-type, 11 = I-type arithmetic.
- `func7`  in  7  instruction bits 31:25.
- `func3`  in  3  instruction bits 14:12.
- `op_a`, `op_b`  in  XLEN  operands (for I-type, `op_b` is the sign-extended immediate).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  result.
- `zero`  out  1  `result` == 0.
- `illegal`  out  1  the request did not decode.
- `AluControl_out`  out  4  decoded op code of the held result.

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL, 1011 MULH, 1100 MULHU, 1101 DIV/DIVU, 1110 REM/REMU, 1111 illegal.
- Decode by `ALUOp_in`:
  - 00 → ADD and 01 → SUB; `func7`/`func3` are ignored.
  - 10 → RV32I R-type when `func7` = 0000000, or 0100000 with `func3` 000/101. M ops when `func7` = 0000001 and `ENABLE_M` = 1. MULHSU (0000001/010) and every other combination → illegal.
  - 11 → I-type: `func3` 000 = ADD (never SUB). `func7` is checked only for `func3` 001 (must be 0000000) and 101 (0000000 = SRL, 0100000 = SRA); otherwise illegal.
- Shift amount is `op_b[log2(XLEN)-1:0]`.
- SLT/SLTU produce 0 or 1, zero-extended.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE: `in_ready`=1. On accept, a simple or illegal op registers its result and goes to DONE. MUL* goes to MUL, DIV*/REM* goes to DIV.
  - MUL: shift-add multiply of operand magnitudes, one bit per cycle, XLEN cycles, 2·XLEN-bit product. Sign is corrected on exit. MUL returns the low half; MULH and MULHU return the high half.
  - DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles. Quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend. Unsigned variants skip magnitude/sign handling.
  - DONE: `out_valid`=1; `result`, `zero`, `illegal`, `AluControl_out` are held stable until `out_ready`. If `out_ready`=1, `in_ready`=1 and a new request may be accepted in the same cycle (same transitions as IDLE). If `out_ready`=1 and `in_valid`=0 → IDLE.
- Divide by zero: quotient = all ones, remainder = `op_a`; no iteration, result in DONE after 1 cycle.
- Signed overflow (−2^(XLEN−1) / −1): quotient = `op_a`, remainder = 0; 1 cycle.
- Illegal: `result`=0, `zero`=1, `illegal`=1, `AluControl_out`=1111; 1 cycle.

## Timing
- Reset (`rst_n`=0 at a clock edge): state → IDLE; `out_valid`=0, `result`=0, `zero`=0, `illegal`=0, `AluControl_out`=0000. `in_ready` reads 0 while `rst_n`=0 and goes to 1 in the first cycle after release. Reset mid-MUL/DIV aborts the operation and produces no output.
- Latency from accept edge to `out_valid`:
  - simple ops, illegal, and divide special cases: 1 cycle;
  - MUL*/DIV*/REM*: XLEN+1 cycles (33 at XLEN=32).
- Throughput: 1 simple op per cycle while `out_ready`=1.
- `in_ready`=0 in MUL/DIV, and in DONE while `out_ready`=0. Inputs presented while `in_ready`=0 are ignored and must be held by the producer.
- All outputs are registered; `in_ready` is combinational from state and `out_ready`.

## Test plan
- ALUOp 10, `func7` 0100000, `func3` 000, a=5, b=7 → after 1 cycle: `result`=0xFFFFFFFE, `AluControl_out`=0110, `zero`=0. Same with ALUOp 01 and a=b=9 → `result`=0, `zero`=1.
- ALUOp 11, `func3` 101, `func7` 0100000, a=0x80000000, b=4 → 0xF8000000. With `func7` 0000001 → `illegal`=1, `result`=0.
- MULH, a=−3, b=0x7FFFFFFF → `out_valid` exactly 33 cycles after accept, `result`=0xFFFFFFFE. MUL with the same operands → 0x80000003.
- DIV with a=−7, b=2 → −3; REM with the same operands → −1. DIVU with b=0 → 0xFFFFFFFF; REMU with a=10, b=0 → 10. DIV with 0x80000000 / −1 → 0x80000000, 1-cycle latency.
- Back-to-back ADDs with `out_ready` held at 1 → one result per cycle. With `out_ready`=0 for 5 cycles → `result` stable and `in_ready`=0 throughout.
- `rst_n` low at cycle 10 of a DIV → `out_valid` stays 0. After release, a new ADD completes normally with `illegal`=0.

Source files
------------

// File: rtl/alu_exec_mc_if.sv
// rtl/alu_exec_mc_if.sv - request/response handshake bundle for alu_exec_mc
interface alu_exec_mc_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp_in;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic [3:0]      AluControl_out;

  modport slave (
    input  in_valid, ALUOp_in, func7, func3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, AluControl_out
  );

  modport master (
    output in_valid, ALUOp_in, func7, func3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, AluControl_out
  );
endinterface

// File: rtl/alu_exec_mc.sv
// rtl/alu_exec_mc.sv - multi-cycle RV32I/M execute unit with valid/ready on both sides
module alu_exec_mc #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  alu_exec_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULH  = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_ILL   = 4'b1111;

  // Returns {signed, op}; signed only matters for the M ops.
  function automatic logic [4:0] decode(input logic [1:0] aop, input logic [6:0] f7,
                                        input logic [2:0] f3);
    logic [3:0] op;
    logic       sgn;
    op  = OP_ILL;
    sgn = 1'b0;
    case (aop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      op = OP_SUB;
          else if (f3 == 3'b101) op = OP_SRA;
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          sgn = ~f3[0];
          case (f3)
            3'b000:         begin op = OP_MUL; sgn = 1'b1; end
            3'b001:         begin op = OP_MULH; sgn = 1'b1; end
            3'b011:         op = OP_MULHU;
            3'b100, 3'b101: op = OP_DIV;
            3'b110, 3'b111: op = OP_REM;
            default:        op = OP_ILL;
          endcase
        end
      end
      default: begin
        case (f3)
          3'b000:  op = OP_ADD;
          3'b001:  op = (f7 == 7'b0000000) ? OP_SLL : OP_ILL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          3'b100:  op = OP_XOR;
          3'b101:  op = (f7 == 7'b0000000) ? OP_SRL :
                        (f7 == 7'b0100000) ? OP_SRA : OP_ILL;
          3'b110:  op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase
    return {sgn, op};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [2*XLEN-1:0] prod_q, prod_d;   // MUL: {acc_hi, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [SHW-1:0]    cnt_q, cnt_d;

  logic [3:0]        dec_op;
  logic              dec_sgn;
  logic              in_ready;
  logic              accept;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   simple_res;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              b_zero, div_ovf, msb_xor;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign {dec_sgn, dec_op} = decode(bus.ALUOp_in, bus.func7, bus.func3);
  assign in_ready = rst_n && (state_q == S_IDLE || (state_q == S_DONE && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;
  assign shamt    = bus.op_b[SHW-1:0];

  assign mag_a   = (dec_sgn && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
  assign mag_b   = (dec_sgn && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
  assign msb_xor = dec_sgn && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
  assign b_zero  = (bus.op_b == '0);
  assign div_ovf = dec_sgn && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;

  assign div_shift = prod_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
  assign quo_fix   = neg_q  ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix   = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

  always_comb begin
    simple_res = '0;
    case (dec_op)
      OP_AND:  simple_res = bus.op_a & bus.op_b;
      OP_OR:   simple_res = bus.op_a | bus.op_b;
      OP_ADD:  simple_res = bus.op_a + bus.op_b;
      OP_XOR:  simple_res = bus.op_a ^ bus.op_b;
      OP_SLL:  simple_res = bus.op_a << shamt;
      OP_SRL:  simple_res = bus.op_a >> shamt;
      OP_SUB:  simple_res = bus.op_a - bus.op_b;
      OP_SRA:  simple_res = $signed(bus.op_a) >>> shamt;
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      default: simple_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN - 1)) begin
          result_d = (ctrl_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        prod_d = div_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN - 1)) begin
          result_d = (ctrl_q == OP_DIV) ? quo_fix : rem_fix;
          state_d  = S_DONE;
        end
      end
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      ctrl_d    = dec_op;
      illegal_d = 1'b0;
      state_d   = S_DONE;
      case (dec_op)
        OP_ILL: begin
          result_d  = '0;
          illegal_d = 1'b1;
        end
        OP_MUL, OP_MULH, OP_MULHU: begin
          prod_d  = {{XLEN{1'b0}}, mag_b};
          opnd_d  = mag_a;
          neg_d   = msb_xor;
          cnt_d   = '0;
          state_d = S_MUL;
        end
        OP_DIV, OP_REM: begin
          if (b_zero) begin
            result_d = (dec_op == OP_DIV) ? {XLEN{1'b1}} : bus.op_a;
          end else if (div_ovf) begin
            result_d = (dec_op == OP_DIV) ? bus.op_a : {XLEN{1'b0}};
          end else begin
            prod_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d  = mag_b;
            neg_d   = msb_xor;
            rneg_d  = dec_sgn && bus.op_a[XLEN-1];
            cnt_d   = '0;
            state_d = S_DIV;
          end
        end
        default: result_d = simple_res;
      endcase
    end

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= 4'b0000;
      prod_q    <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == S_DONE);
  assign bus.result         = result_q;
  assign bus.zero           = zero_q;
  assign bus.illegal        = illegal_q;
  assign bus.AluControl_out = ctrl_q;
endmodule

// File: tb/tb_alu_exec_mc.sv
// tb/tb_alu_exec_mc.sv - scoreboard bench for alu_exec_mc with directed vectors
module tb_alu_exec_mc;
  logic clk;
  logic rst_n;

  alu_exec_mc_if #(.XLEN(32)) bus ();

  alu_exec_mc #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ill;
    logic [3:0]  ctrl;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_wait = 0;
  bit   seen = 1'b0;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h with no pending request", bus.result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, ".result"},  bus.result, e.res);
          chk({e.name, ".zero"},    32'(bus.zero), 32'(e.res == 32'd0));
          chk({e.name, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
          chk({e.name, ".ctrl"},    32'(bus.AluControl_out), 32'(e.ctrl));
          chk({e.name, ".latency"}, 32'(first_cyc - e.acc), 32'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  // Called and returns at posedge+1; holds the request until accepted.
  task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic eill, input logic [3:0] ectrl, input int lat,
                       input string nm, input bit push);
    int t;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.ALUOp_in = aop;
    bus.func7    = f7;
    bus.func3    = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    t = 0;
    #1;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    last_wait = t;
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s.accept_timeout: in_ready stayed 0 for %0d cycles", nm, t);
    end else if (push) begin
      e.name = nm; e.res = er; e.ill = eill; e.ctrl = ectrl; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ov;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ALUOp_in  = 2'b00;
    bus.func7     = 7'd0;
    bus.func3     = 3'd0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result",    bus.result, 32'd0);
    chk("rst.zero",      32'(bus.zero), 32'd0);
    chk("rst.illegal",   32'(bus.illegal), 32'd0);
    chk("rst.ctrl",      32'(bus.AluControl_out), 32'd0);
    chk("rst.in_ready",  32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready_after", 32'(bus.in_ready), 32'd1);

    issue(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 4'b0110, 1, "sub_r", 1'b1);
    issue(2'b01, 7'b1111111, 3'b111, 32'd9, 32'd9, 32'h0, 1'b0, 4'b0110, 1, "sub_br", 1'b1);
    issue(2'b11, 7'b0100000, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 4'b0111, 1, "srai", 1'b1);
    issue(2'b11, 7'b0000001, 3'b101, 32'h80000000, 32'd4, 32'h0, 1'b1, 4'b1111, 1, "srai_bad", 1'b1);
    issue(2'b11, 7'b0100000, 3'b000, 32'd10, 32'hFFFFFFFF, 32'd9, 1'b0, 4'b0010, 1, "addi_neg", 1'b1);
    issue(2'b11, 7'b0000001, 3'b001, 32'd1, 32'd3, 32'h0, 1'b1, 4'b1111, 1, "slli_bad", 1'b1);
    issue(2'b10, 7'b0000000, 3'b001, 32'd1, 32'd33, 32'd2, 1'b0, 4'b0100, 1, "sll_wrap", 1'b1);
    issue(2'b10, 7'b0000000, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 4'b1000, 1, "slt", 1'b1);
    issue(2'b10, 7'b0000000, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'b1001, 1, "sltu", 1'b1);
    issue(2'b10, 7'b0000001, 3'b010, 32'd2, 32'd3, 32'h0, 1'b1, 4'b1111, 1, "mulhsu", 1'b1);
    issue(2'b10, 7'b0000001, 3'b001, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 4'b1011, 33, "mulh", 1'b1);
    issue(2'b10, 7'b0000001, 3'b000, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000003, 1'b0, 4'b1010, 33, "mul", 1'b1);
    issue(2'b10, 7'b0000001, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 4'b1100, 33, "mulhu", 1'b1);
    issue(2'b10, 7'b0000001, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 4'b1101, 33, "div", 1'b1);
    issue(2'b10, 7'b0000001, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 4'b1110, 33, "rem", 1'b1);
    issue(2'b10, 7'b0000001, 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 4'b1110, 33, "rem_negb", 1'b1);
    issue(2'b10, 7'b0000001, 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1'b0, 4'b1101, 33, "divu", 1'b1);
    issue(2'b10, 7'b0000001, 3'b101, 32'h00001234, 32'd0, 32'hFFFFFFFF, 1'b0, 4'b1101, 1, "divu_by0", 1'b1);
    issue(2'b10, 7'b0000001, 3'b111, 32'd10, 32'd0, 32'd10, 1'b0, 4'b1110, 1, "remu_by0", 1'b1);
    issue(2'b10, 7'b0000001, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 4'b1101, 1, "div_ovf", 1'b1);
    issue(2'b10, 7'b0000001, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 4'b1110, 1, "rem_ovf", 1'b1);
    drain();

    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 7'd0, 3'd0, 32'(i), 32'(10 * i), 32'(11 * i), 1'b0, 4'b0010, 1, "b2b_add", 1'b1);
      if (i > 0) chk("b2b_wait", 32'(last_wait), 32'd0);
    end
    drain();

    bus.out_ready = 1'b0;
    issue(2'b00, 7'd0, 3'd0, 32'd100, 32'd23, 32'd123, 1'b0, 4'b0010, 1, "stall_add", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall.result",    bus.result, 32'd123);
      chk("stall.in_ready",  32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    drain();

    issue(2'b10, 7'b0000001, 3'b100, 32'd1000, 32'd7, 32'd0, 1'b0, 4'b1101, 33, "div_abort", 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    chk("abort.out_valid_count", 32'(ov), 32'd0);
    @(posedge clk);
    #1;
    issue(2'b00, 7'd0, 3'd0, 32'd40, 32'd2, 32'd42, 1'b0, 4'b0010, 1, "post_rst_add", 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
